// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array input skewer.
//   skew_state_e : skewer FSM states
//   act_vec_t    : one activation element per SA row
//   DRAIN_2X2    : number of zero drain beats needed in 2x2 mode
package sa_pkg;

  localparam int SA_BIT_WIDTH = 4;
  localparam int SA_DIMENSION = 4;
  localparam int DRAIN_2X2    = 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } skew_state_e;

  typedef logic [SA_DIMENSION-1:0][SA_BIT_WIDTH-1:0] act_vec_t;

endpackage

// File: rtl/sa_skew_delay_line.sv
// Shift chain of DEPTH registers used as one skew lane.
// Ports:
//   clk        rising-edge clock
//   rst_ni     asynchronous active-low clear of every stage
//   shift_en_i 1 = shift din_i in and move every stage one step
//   din_i      element entering the lane
//   dout_o     oldest stage (lane output)
module sa_skew_delay_line #(
  parameter int BIT_WIDTH = 4,
  parameter int DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 rst_ni,
  input  logic                 shift_en_i,
  input  logic [BIT_WIDTH-1:0] din_i,
  output logic [BIT_WIDTH-1:0] dout_o
);

  logic [DEPTH-1:0][BIT_WIDTH-1:0] stage_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else if (shift_en_i) begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sa_input_skewer.sv
// Feeds the systolic array's input_left bus. Accepts one activation vector per
// beat, delays row r by r extra beats so operands meet diagonally, and flushes
// the lanes with zero beats at frame end. pe_enable tells the array when the
// skew pipeline advanced, so data and enable leave the registers together.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   out_model  1 = 4x4 mode, 0 = 2x2 mode (latched when a frame starts)
//   sa_stall   downstream hold; nothing advances while high
//   in_valid / in_ready / in_last / in_vec : upstream beat handshake
//   out_left   skewed data, row r in bits [r*BIT_WIDTH +: BIT_WIDTH]
//   pe_enable  array consumes out_left this cycle
//   busy       frame in progress
//   frame_done one-cycle pulse after the final drain beat
module sa_input_skewer
  import sa_pkg::*;
#(
  parameter int BIT_WIDTH = SA_BIT_WIDTH,
  parameter int DIMENSION = SA_DIMENSION
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           out_model,
  input  logic                           sa_stall,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [DIMENSION*BIT_WIDTH-1:0] in_vec,
  output logic [DIMENSION*BIT_WIDTH-1:0] out_left,
  output logic                           pe_enable,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int CW = $clog2(DIMENSION) + 1;

  skew_state_e   state_q;
  logic          mode_q;
  logic [CW-1:0] drain_cnt_q;
  logic          pe_enable_q;
  logic          drain_end_q;
  logic          frame_done_q;

  logic accept;
  logic drain_adv;
  logic advance;
  logic in_drain;
  logic mode_eff;

  // Number of zero beats needed to empty the deepest active lane.
  function automatic logic [CW-1:0] drain_load(input logic mode_4x4);
    return mode_4x4 ? CW'(DIMENSION - 1) : CW'(DRAIN_2X2);
  endfunction

  assign in_drain  = (state_q == DRAIN);
  assign in_ready  = !sa_stall && ((state_q == IDLE) || (state_q == STREAM));
  assign accept    = in_valid && in_ready;
  assign drain_adv = in_drain && !sa_stall;
  assign advance   = accept || drain_adv;
  // The first beat of a frame must already use the mode being latched.
  assign mode_eff  = (state_q == IDLE) ? out_model : mode_q;

  genvar gi;
  generate
    for (gi = 0; gi < DIMENSION; gi++) begin : g_lane
      logic [BIT_WIDTH-1:0] lane_din;

      if (gi >= 2) begin : g_gated
        // Rows beyond the 2x2 sub-array are fed zeros in 2x2 mode.
        assign lane_din = (in_drain || !mode_eff) ? '0
                                                  : in_vec[gi*BIT_WIDTH +: BIT_WIDTH];
      end else begin : g_always
        assign lane_din = in_drain ? '0 : in_vec[gi*BIT_WIDTH +: BIT_WIDTH];
      end

      sa_skew_delay_line #(
        .BIT_WIDTH(BIT_WIDTH),
        .DEPTH    (gi + 1)
      ) u_lane (
        .clk       (clk),
        .rst_ni    (reset),
        .shift_en_i(advance),
        .din_i     (lane_din),
        .dout_o    (out_left[gi*BIT_WIDTH +: BIT_WIDTH])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mode_q       <= 1'b1;
      drain_cnt_q  <= '0;
      pe_enable_q  <= 1'b0;
      drain_end_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pe_enable_q  <= advance;
      // Two-stage pulse: the FSM is back in IDLE one cycle before frame_done.
      drain_end_q  <= 1'b0;
      frame_done_q <= drain_end_q;
      case (state_q)
        IDLE: begin
          if (accept) begin
            mode_q <= out_model;
            if (in_last) begin
              state_q     <= DRAIN;
              drain_cnt_q <= drain_load(out_model);
            end else begin
              state_q <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept && in_last) begin
            state_q     <= DRAIN;
            drain_cnt_q <= drain_load(mode_q);
          end
        end
        DRAIN: begin
          if (drain_adv) begin
            if (drain_cnt_q == CW'(1)) begin
              state_q     <= IDLE;
              drain_cnt_q <= '0;
              drain_end_q <= 1'b1;
            end else begin
              drain_cnt_q <= drain_cnt_q - CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pe_enable  = pe_enable_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sa_input_skewer.sv
module tb_sa_input_skewer;

  localparam int BW  = 4;
  localparam int DIM = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              out_model;
  logic              sa_stall;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [DIM*BW-1:0] in_vec;
  logic [DIM*BW-1:0] out_left;
  logic              pe_enable;
  logic              busy;
  logic              frame_done;

  sa_input_skewer #(.BIT_WIDTH(BW), .DIMENSION(DIM)) dut (
    .clk       (clk),
    .reset     (reset),
    .out_model (out_model),
    .sa_stall  (sa_stall),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_vec    (in_vec),
    .out_left  (out_left),
    .pe_enable (pe_enable),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pe_count = 0;
  logic [DIM*BW-1:0] sb[$];
  logic [DIM*BW-1:0] frame_beats[$];
  logic s_ready, s_busy, s_fd, s_pe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected out_left for every enabled output beat of a frame: row r of
  // output beat j carries row r of input beat j-r, zero outside the frame
  // or on rows idle in 2x2 mode.
  task automatic push_frame(input bit mode_4x4);
    int n;
    int d;
    logic [DIM*BW-1:0] e;
    logic [DIM*BW-1:0] b;
    n = frame_beats.size();
    d = mode_4x4 ? DIM - 1 : 1;
    for (int j = 0; j < n + d; j++) begin
      e = '0;
      for (int r = 0; r < DIM; r++) begin
        if ((mode_4x4 || r < 2) && (j - r) >= 0 && (j - r) < n) begin
          b = frame_beats[j-r];
          e[r*BW +: BW] = b[r*BW +: BW];
        end
      end
      sb.push_back(e);
    end
  endtask

  // One clock: sample outputs at the falling edge, score enabled beats,
  // then return 1 time unit after the rising edge.
  task automatic tick();
    logic [DIM*BW-1:0] e;
    @(negedge clk);
    s_ready = in_ready;
    s_busy  = busy;
    s_fd    = frame_done;
    s_pe    = pe_enable;
    if (pe_enable) begin
      pe_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow observed=%0h expected=no_beat", out_left);
      end else begin
        e = sb.pop_front();
        chk("out_left", 32'(out_left), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DIM*BW-1:0] v, input logic last);
    in_valid = 1'b1;
    in_vec   = v;
    in_last  = last;
    tick();
    chk("in_ready_beat", 32'(s_ready), 32'd1);
  endtask

  task automatic drain_wait(input int nd);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < nd; i++) begin
      tick();
      chk("drain_busy", 32'(s_busy), 32'd1);
      chk("drain_ready", 32'(s_ready), 32'd0);
    end
    tick();
    chk("idle_busy", 32'(s_busy), 32'd0);
    chk("idle_ready", 32'(s_ready), 32'd1);
    chk("idle_fd", 32'(s_fd), 32'd0);
    tick();
    chk("frame_done", 32'(s_fd), 32'd1);
    chk("fd_pe", 32'(s_pe), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    out_model = 1'b1;
    sa_stall  = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_vec    = '0;

    // Power-on reset state
    tick();
    tick();
    chk("rst_out_left", 32'(out_left), 32'd0);
    chk("rst_pe", 32'(pe_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    tick();

    // Test 1: asynchronous reset mid-STREAM
    frame_beats = {16'h4321, 16'h8765};
    push_frame(1'b1);
    send_beat(16'h4321, 1'b0);
    send_beat(16'h8765, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_out_left", 32'(out_left), 32'd0);
    chk("midrst_pe", 32'(pe_enable), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_fd", 32'(frame_done), 32'd0);
    sb.delete();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("postrst_busy", 32'(s_busy), 32'd0);
    chk("postrst_pe", 32'(s_pe), 32'd0);

    // Test 2: 4x4 frame, three beats, no stall
    pe_count = 0;
    out_model = 1'b1;
    frame_beats = {16'h4321, 16'h8765, 16'hCBA9};
    push_frame(1'b1);
    send_beat(16'h4321, 1'b0);
    send_beat(16'h8765, 1'b0);
    send_beat(16'hCBA9, 1'b1);
    drain_wait(3);
    chk("t2_pe_count", 32'(pe_count), 32'd6);

    // Test 3: 2x2 frame, rows 2 and 3 stay zero, one drain beat
    pe_count = 0;
    out_model = 1'b0;
    frame_beats = {16'h4321, 16'h8765};
    push_frame(1'b0);
    send_beat(16'h4321, 1'b0);
    send_beat(16'h8765, 1'b1);
    drain_wait(1);
    chk("t3_pe_count", 32'(pe_count), 32'd3);

    // Test 4: two-cycle stalls mid-STREAM and mid-DRAIN
    pe_count = 0;
    out_model = 1'b1;
    frame_beats = {16'h3210, 16'h7654, 16'hBA98};
    push_frame(1'b1);
    send_beat(16'h3210, 1'b0);
    sa_stall = 1'b1;
    in_valid = 1'b1;
    in_vec   = 16'h7654;
    tick();
    chk("stall_s_ready1", 32'(s_ready), 32'd0);
    chk("stall_s_pe1", 32'(s_pe), 32'd1);
    tick();
    chk("stall_s_ready2", 32'(s_ready), 32'd0);
    chk("stall_s_pe2", 32'(s_pe), 32'd0);
    sa_stall = 1'b0;
    send_beat(16'h7654, 1'b0);
    send_beat(16'hBA98, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    chk("stall_d_busy0", 32'(s_busy), 32'd1);
    sa_stall = 1'b1;
    tick();
    chk("stall_d_ready1", 32'(s_ready), 32'd0);
    chk("stall_d_pe1", 32'(s_pe), 32'd1);
    tick();
    chk("stall_d_pe2", 32'(s_pe), 32'd0);
    chk("stall_d_busy2", 32'(s_busy), 32'd1);
    sa_stall = 1'b0;
    drain_wait(2);
    chk("t4_pe_count", 32'(pe_count), 32'd6);

    // Test 5: bubble in the middle of a frame
    pe_count = 0;
    frame_beats = {16'h1357, 16'h2468};
    push_frame(1'b1);
    send_beat(16'h1357, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("bubble_pe_prev", 32'(s_pe), 32'd1);
    chk("bubble_ready", 32'(s_ready), 32'd1);
    chk("bubble_busy", 32'(s_busy), 32'd1);
    send_beat(16'h2468, 1'b1);
    chk("bubble_pe", 32'(s_pe), 32'd0);
    drain_wait(3);
    chk("t5_pe_count", 32'(pe_count), 32'd5);

    // Test 6: single-beat frame, next frame offered during DRAIN in 2x2 mode
    pe_count = 0;
    out_model = 1'b1;
    frame_beats = {16'h9ABC};
    push_frame(1'b1);
    send_beat(16'h9ABC, 1'b1);
    frame_beats = {16'h5678};
    push_frame(1'b0);
    out_model = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 16'h5678;
    in_last   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_drain_ready", 32'(s_ready), 32'd0);
      chk("t6_drain_busy", 32'(s_busy), 32'd1);
    end
    tick();
    chk("t6_accept_ready", 32'(s_ready), 32'd1);
    chk("t6_accept_busy", 32'(s_busy), 32'd0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    chk("t6_fd_overlap", 32'(s_fd), 32'd1);
    chk("t6_f2_busy", 32'(s_busy), 32'd1);
    chk("t6_f2_ready", 32'(s_ready), 32'd0);
    tick();
    chk("t6_f2_idle", 32'(s_busy), 32'd0);
    chk("t6_f2_fd0", 32'(s_fd), 32'd0);
    tick();
    chk("t6_f2_fd", 32'(s_fd), 32'd1);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);
    chk("t6_pe_count", 32'(pe_count), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
